// File: rtl/gp_reg.sv
// gp_reg: 8-bit general-purpose datapath register with three tri-state
// drivers (main bus, ALU LHS, ALU RHS) and an always-driven display copy.
//
// Ports:
//   CLK            system clock, all state changes on rising edge
//   RST            synchronous reset, active-high, clears the register
//   LOAD_bar       active-low load enable, captures BUS_in at rising CLK
//   ASSERT_bar     active-low enable for BUS_out driver
//   ASSERT_LHS_bar active-low enable for LHS_out driver
//   ASSERT_RHS_bar active-low enable for RHS_out driver
//   INC_bar        active-low increment (only with GPREG_INCDEC_EN)
//   DEC_bar        active-low decrement (only with GPREG_INCDEC_EN)
//   BUS_in         data from main bus
//   BUS_out        tri-state drive onto main bus
//   LHS_out        tri-state drive onto ALU left operand bus
//   RHS_out        tri-state drive onto ALU right operand bus
//   display_value  current register contents, never tri-stated
//
// Build option:
//   GPREG_INCDEC_EN  adds INC_bar/DEC_bar in-place increment/decrement.
//   Priority is RST > LOAD > INC/DEC; INC and DEC together hold the value.

module gp_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_bar,
    input  logic             ASSERT_bar,
    input  logic             ASSERT_LHS_bar,
    input  logic             ASSERT_RHS_bar,
`ifdef GPREG_INCDEC_EN
    input  logic             INC_bar,
    input  logic             DEC_bar,
`endif
    input  logic [WIDTH-1:0] BUS_in,
    output logic [WIDTH-1:0] BUS_out,
    output logic [WIDTH-1:0] LHS_out,
    output logic [WIDTH-1:0] RHS_out,
    output logic [WIDTH-1:0] display_value
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (!LOAD_bar) begin
            q_d = BUS_in;
        end
`ifdef GPREG_INCDEC_EN
        // Both strobes low cancel out, so the value holds.
        else if (!INC_bar && DEC_bar) begin
            q_d = q_q + WIDTH'(1);
        end else if (INC_bar && !DEC_bar) begin
            q_d = q_q - WIDTH'(1);
        end
`endif
    end

    // No power-up initialisation: Q is undefined until the first reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Drivers are purely combinational and follow their enables directly;
    // reset only affects what is driven, not whether it is driven.
    assign BUS_out       = !ASSERT_bar     ? q_q : {WIDTH{1'bz}};
    assign LHS_out       = !ASSERT_LHS_bar ? q_q : {WIDTH{1'bz}};
    assign RHS_out       = !ASSERT_RHS_bar ? q_q : {WIDTH{1'bz}};
    assign display_value = q_q;

endmodule

// File: tb/tb_gp_reg.sv
// tb_gp_reg: directed and randomized checks of gp_reg
// against a behavioural model of the register contents.

module tb_gp_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_n;
  logic       as_n;
  logic       al_n;
  logic       ar_n;
`ifdef GPREG_INCDEC_EN
  logic       inc_n;
  logic       dec_n;
`endif
  logic [7:0] bus_in;
  wire  [7:0] bus_out;
  wire  [7:0] lhs_out;
  wire  [7:0] rhs_out;
  wire  [7:0] disp;

  int n_chk  = 0;
  int n_fail = 0;
  int mq     = 0;

  always #5 clk = ~clk;

  gp_reg #(.WIDTH(8)) dut (
    .CLK           (clk),
    .RST           (rst),
    .LOAD_bar      (ld_n),
    .ASSERT_bar    (as_n),
    .ASSERT_LHS_bar(al_n),
    .ASSERT_RHS_bar(ar_n),
`ifdef GPREG_INCDEC_EN
    .INC_bar       (inc_n),
    .DEC_bar       (dec_n),
`endif
    .BUS_in        (bus_in),
    .BUS_out       (bus_out),
    .LHS_out       (lhs_out),
    .RHS_out       (rhs_out),
    .display_value (disp)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] drv(input logic en_n,
                                     input int v);
    logic [7:0] r;
    r = en_n ? 8'bz : 8'(v);
    return r;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".disp"}, disp, 8'(mq));
    chk({tag, ".bus"}, bus_out, drv(as_n, mq));
    chk({tag, ".lhs"}, lhs_out, drv(al_n, mq));
    chk({tag, ".rhs"}, rhs_out, drv(ar_n, mq));
  endtask

  task automatic model();
    if (rst)
      mq = 0;
    else if (!ld_n)
      mq = int'(bus_in);
`ifdef GPREG_INCDEC_EN
    else if (!inc_n && dec_n)
      mq = (mq + 1) % 256;
    else if (inc_n && !dec_n)
      mq = (mq + 255) % 256;
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model();
    #1;
    chk_all(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; ld_n = 1; bus_in = 8'h00;
`ifdef GPREG_INCDEC_EN
    inc_n = 1; dec_n = 1;
`endif
  endtask

  task automatic asrt(input logic b, input logic l,
                      input logic r, input string tag);
    as_n = b; al_n = l; ar_n = r;
    #1;
    chk_all(tag);
  endtask

  initial begin
    idle();
    as_n = 1; al_n = 1; ar_n = 1;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    step("reset");
    rst = 0;
    #1;
    chk("reset_zero", disp, 8'h00);

    ld_n = 0; bus_in = 8'hA8;
    step("load_a8");
    ld_n = 1; bus_in = 8'h8A;
    step("hold_a8");
    chk("hold_val", disp, 8'hA8);

    asrt(0, 1, 1, "en_bus");
    asrt(1, 0, 1, "en_lhs");
    asrt(1, 1, 0, "en_rhs");
    asrt(0, 0, 0, "en_all");
    asrt(1, 1, 1, "en_none");

    rst = 1; ld_n = 0; bus_in = 8'h55;
    step("rst_wins");
    chk("rst_wins_val", disp, 8'h00);
    rst = 0;
    step("load_55");
    chk("load_55_val", disp, 8'h55);

    as_n = 0; ld_n = 0; bus_in = 8'h3C;
    step("self_load");
    idle();

`ifdef GPREG_INCDEC_EN
    ld_n = 0; bus_in = 8'hFF;
    step("load_ff");
    idle(); inc_n = 0;
    step("inc_wrap");
    chk("inc_wrap_val", disp, 8'h00);
    idle(); dec_n = 0;
    step("dec_wrap");
    chk("dec_wrap_val", disp, 8'hFF);
    idle(); inc_n = 0; dec_n = 0;
    step("both_hold");
    chk("both_hold_val", disp, 8'hFF);
    idle(); ld_n = 0; bus_in = 8'h10; inc_n = 0;
    step("load_pri");
    chk("load_pri_val", disp, 8'h10);
    idle();
`endif

    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 15) == 0);
      ld_n   = $urandom_range(0, 1) == 1;
      bus_in = 8'($urandom);
      as_n   = $urandom_range(0, 1) == 1;
      al_n   = $urandom_range(0, 1) == 1;
      ar_n   = $urandom_range(0, 1) == 1;
`ifdef GPREG_INCDEC_EN
      inc_n  = $urandom_range(0, 1) == 1;
      dec_n  = $urandom_range(0, 1) == 1;
`endif
      step("rand");
      asrt($urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, "rand_en");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gp_reg.md
Name: gp_reg

Overview:
- General-purpose data register for the 8-bit datapath.
- Loads from the main bus on a clock edge.
- Can independently drive its stored value onto three tri-state buses: main BUS, ALU LHS and ALU RHS.
- A non-tri-stated copy of the contents is always available on display_value for front-panel LEDs and debug.

Parameters:
- WIDTH, 8: data width of register, buses and display.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-high.
- LOAD_bar  input  1  active-low load enable; captures BUS_in at rising CLK.
- ASSERT_bar  input  1  active-low enable for BUS_out driver.
- ASSERT_LHS_bar  input  1  active-low enable for LHS_out driver.
- ASSERT_RHS_bar  input  1  active-low enable for RHS_out driver.
- BUS_in  input  WIDTH  data from main bus.
- BUS_out  output  WIDTH  tri-state drive onto main bus.
- LHS_out  output  WIDTH  tri-state drive onto ALU left operand bus.
- RHS_out  output  WIDTH  tri-state drive onto ALU right operand bus.
- display_value  output  WIDTH  current register contents, always driven.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Storage: one WIDTH-bit register, value Q.
- Reset:
  - RST high at rising CLK sets Q = 0, overriding all other controls.
  - display_value = 0 after reset.
  - Tri-state outputs stay governed only by their enables: reset does not force Z, and an asserted output drives 0 after reset.
- Load:
  - At rising CLK with RST=0 and LOAD_bar=0: Q <= BUS_in.
  - LOAD_bar=1: Q holds; BUS_in changes are ignored.
  - Latency is one edge: new value visible on display_value and any asserted output immediately after that edge.
- Power-up before any reset: Q is undefined (X in simulation); no other initialisation is required.
- Output drivers, purely combinational, no clock involvement:
  - BUS_out = Q when ASSERT_bar=0, else all-Z.
  - LHS_out = Q when ASSERT_LHS_bar=0, else all-Z.
  - RHS_out = Q when ASSERT_RHS_bar=0, else all-Z.
  - Enables are independent; any combination, including all three together, is legal.
  - An output follows enable changes with zero cycles of latency.
- display_value = Q at all times, never Z, independent of the assert lines.
- Simultaneous LOAD_bar=0 and ASSERT_bar=0 (register drives the bus it loads from):
  - Legal; Q takes BUS_in sampled at the edge.
  - Avoiding external contention is the controller's responsibility.
- Enables are level-sensitive; no glitch filtering.

Optional Feature:
- Macro: GPREG_INCDEC_EN.
- Defined: adds inputs INC_bar and DEC_bar (1 bit, active-low).
  - At rising CLK with RST=0 and LOAD_bar=1: INC_bar=0 gives Q <= Q+1; DEC_bar=0 gives Q <= Q-1.
  - Arithmetic is modulo 2^WIDTH: FF+1 = 00, 00-1 = FF.
  - INC_bar and DEC_bar both low: Q holds.
  - Priority: RST > LOAD > INC/DEC.
- Not defined: ports absent; behaviour exactly as above.

Test Plan:
- All asserts high, after reset: BUS_out, LHS_out and RHS_out all read 8'bZ; display_value = 00.
- LOAD_bar=0, BUS_in=A8, one rising CLK, then LOAD_bar=1: display_value = A8; all three outputs still Z.
- LOAD_bar=1, BUS_in=8A, clock edge: display_value remains A8.
- ASSERT_bar=0 only -> BUS_out=A8, LHS/RHS Z. ASSERT_LHS_bar=0 only -> LHS_out=A8, others Z. ASSERT_RHS_bar=0 only -> RHS_out=A8, others Z. All three low -> all read A8.
- Q=A8, RST=1 with LOAD_bar=0 and BUS_in=55 at an edge: display_value = 00 (reset wins). Next edge with RST=0: display_value = 55.
- With GPREG_INCDEC_EN, load FF:
  - INC_bar=0 one edge -> 00.
  - DEC_bar=0 one edge -> FF.
  - Both low -> FF held.
  - LOAD_bar=0 with BUS_in=10 and INC_bar=0 -> 10.
